// File: rtl/csl23bit_bist_if.sv
// Bus between the csl23bit self-test engine, its controller (start/status) and the
// 23-bit carry-select adder/subtractor under test.
interface csl23bit_bist_if #(
   parameter int unsigned WIDTH = 23
);
   logic             start;
   logic             busy;
   logic             done;
   logic             pass;
   logic [7:0]       err_count;
   logic [7:0]       first_err_idx;
   logic [WIDTH-1:0] dut_a;
   logic [WIDTH-1:0] dut_b;
   logic             dut_cin;
   logic [WIDTH-1:0] dut_sum;
   logic             dut_cout;

   // The engine side drives operands and status, and receives start and the adder result.
   modport master (
      input  start, dut_sum, dut_cout,
      output busy, done, pass, err_count, first_err_idx, dut_a, dut_b, dut_cin
   );

   modport slave (
      output start, dut_sum, dut_cout,
      input  busy, done, pass, err_count, first_err_idx, dut_a, dut_b, dut_cin
   );
endinterface

// File: rtl/csl23bit_bist.sv
// Self-test engine for the csl23bit add/sub unit: applies four corner vectors then
// LFSR-derived vectors, checks sum/cout against a reference, and reports the outcome.
module csl23bit_bist #(
   parameter int unsigned WIDTH         = 23,
   parameter int unsigned NUM_VECTORS   = 101,
   parameter logic [31:0] SEED          = 32'hACE1_2025,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned CHECK_COUT    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   csl23bit_bist_if.master bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GEN    = 3'd1;
   localparam logic [2:0] S_APPLY  = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   localparam logic [7:0] LAST_IDX    = 8'(NUM_VECTORS - 1);
   localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic [31:0]      lfsr_q, lfsr_d;
   logic [7:0]       idx_q, idx_d;
   logic [3:0]       settle_q, settle_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [7:0]       err_q, err_d;
   logic [7:0]       first_q, first_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cin_q, cin_d;

   logic [31:0]      lfsr_nx;
   logic [WIDTH:0]   expect_w;
   logic             mismatch;

   // Fibonacci LFSR, taps 32,22,2,1, shifting left with feedback into bit 0.
   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
   endfunction

   function automatic logic [WIDTH:0] ref_addsub(input logic [WIDTH-1:0] op_a,
                                                 input logic [WIDTH-1:0] op_b,
                                                 input logic             sub);
      logic [WIDTH-1:0] bx;
      bx = sub ? ~op_b : op_b;
      return {1'b0, op_a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
   endfunction

   assign lfsr_nx  = lfsr_step(lfsr_q);
   assign expect_w = ref_addsub(a_q, b_q, cin_q);
   assign mismatch = (bus.dut_sum != expect_w[WIDTH-1:0]) ||
                     ((CHECK_COUT != 0) && (bus.dut_cout != expect_w[WIDTH]));

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      first_d  = first_q;
      a_d      = a_q;
      b_d      = b_q;
      cin_d    = cin_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               err_d   = 8'd0;
               first_d = 8'hFF;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               lfsr_d  = SEED;
               idx_d   = 8'd0;
               busy_d  = 1'b1;
               state_d = S_GEN;
            end
         end
         S_GEN: begin
            settle_d = 4'd0;
            if (idx_q < 8'd4) begin
               case (idx_q[1:0])
                  2'd0:    begin a_d = WIDTH'(255);         b_d = WIDTH'(254); cin_d = 1'b1; end
                  2'd1:    begin a_d = WIDTH'(1);           b_d = WIDTH'(16);  cin_d = 1'b0; end
                  2'd2:    begin a_d = WIDTH'(0);           b_d = WIDTH'(0);   cin_d = 1'b1; end
                  default: begin a_d = WIDTH'(23'h7FFFFF);  b_d = WIDTH'(1);   cin_d = 1'b0; end
               endcase
            end else begin
               // Random vectors consume two LFSR steps: A from the current word, B/mode from the next.
               a_d    = lfsr_q[WIDTH-1:0];
               b_d    = lfsr_nx[WIDTH-1:0];
               cin_d  = lfsr_nx[31];
               lfsr_d = lfsr_step(lfsr_nx);
            end
            state_d = S_APPLY;
         end
         S_APPLY: begin
            if (settle_q == LAST_SETTLE) state_d = S_CHECK;
            else                         settle_d = settle_q + 4'd1;
         end
         S_CHECK: begin
            if (mismatch) begin
               if (err_q != 8'hFF)   err_d   = err_q + 8'd1;
               if (first_q == 8'hFF) first_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = S_GEN;
            end
         end
         S_FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_q == 8'd0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lfsr_q   <= SEED;
         idx_q    <= 8'd0;
         settle_q <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= 8'd0;
         first_q  <= 8'hFF;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         first_q  <= first_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.err_count     = err_q;
   assign bus.first_err_idx = first_q;
   assign bus.dut_a         = a_q;
   assign bus.dut_b         = b_q;
   assign bus.dut_cin       = cin_q;

endmodule

// File: tb/tb_csl23bit_bist.sv
// Bench for csl23bit_bist: golden adder with injectable faults, scoreboard of expected
// operand vectors, and directed runs covering reset, faults, abort and restart.
module tb_csl23bit_bist;

   localparam int unsigned W    = 23;
   localparam int unsigned N    = 101;
   localparam logic [31:0] SEED = 32'hACE1_2025;
   localparam int          RUN_CYCLES = N * (2 + 1) + 2;

   localparam logic [W-1:0] C_A   [4] = '{23'd255, 23'd1, 23'd0, 23'h7FFFFF};
   localparam logic [W-1:0] C_B   [4] = '{23'd254, 23'd16, 23'd0, 23'd1};
   localparam logic         C_CIN [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   localparam logic [W-1:0] C_SUM [4] = '{23'd1, 23'd17, 23'd0, 23'd0};
   localparam logic         C_CO  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
   } vec_t;

   logic clk;
   logic rst_n;
   int   fault_mode;
   int   tests;
   int   fails;
   int   cyc;
   int   pulse_at;
   int   stuck_errs;
   vec_t sb[$];

   csl23bit_bist_if #(.WIDTH(W)) bus ();
   csl23bit_bist_if #(.WIDTH(W)) bus_nc ();

   csl23bit_bist #(.WIDTH(W), .NUM_VECTORS(N), .SEED(SEED), .SETTLE_CYCLES(1), .CHECK_COUT(1))
      u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   csl23bit_bist #(.WIDTH(W), .NUM_VECTORS(N), .SEED(SEED), .SETTLE_CYCLES(1), .CHECK_COUT(0))
      u_nc (.clk(clk), .rst_n(rst_n), .bus(bus_nc));

   // Subtract written as A-B with carry = no-borrow, which equals A + ~B + 1 on W+1 bits.
   function automatic logic [W:0] add_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic [W-1:0] d;
      if (sub) begin
         d = a - b;
         return {(a >= b), d};
      end
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
      return {l[30:0], ^(l & 32'h8020_0003)};
   endfunction

   logic [W:0] gold, gold_nc;
   assign gold            = add_ref(bus.dut_a, bus.dut_b, bus.dut_cin);
   assign bus.dut_sum     = (fault_mode == 1) ? {gold[W-1:1], 1'b0} : gold[W-1:0];
   assign bus.dut_cout    = (fault_mode == 2) ? ~gold[W] : gold[W];
   assign gold_nc         = add_ref(bus_nc.dut_a, bus_nc.dut_b, bus_nc.dut_cin);
   assign bus_nc.dut_sum  = gold_nc[W-1:0];
   assign bus_nc.dut_cout = ~gold_nc[W];
   assign bus_nc.start    = bus.start;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic build_queue();
      logic [31:0] l, ln;
      logic [W:0]  r;
      vec_t        v;
      sb.delete();
      stuck_errs = 0;
      l = SEED;
      for (int k = 0; k < int'(N); k++) begin
         if (k < 4) begin
            v.a = C_A[k]; v.b = C_B[k]; v.cin = C_CIN[k];
         end else begin
            ln    = lfsr_adv(l);
            v.a   = l[W-1:0];
            v.b   = ln[W-1:0];
            v.cin = ln[31];
            l     = lfsr_adv(ln);
         end
         r = add_ref(v.a, v.b, v.cin);
         if (r[0]) stuck_errs++;
         sb.push_back(v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      bus.start = (pulse_at != 0) && (cyc + 1 == pulse_at);
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".busy"},  32'(bus.busy), 32'd0);
      check({tag, ".done"},  32'(bus.done), 32'd0);
      check({tag, ".pass"},  32'(bus.pass), 32'd0);
      check({tag, ".err"},   32'(bus.err_count), 32'd0);
      check({tag, ".first"}, 32'(bus.first_err_idx), 32'hFF);
      check({tag, ".a"},     32'(bus.dut_a), 32'd0);
      check({tag, ".b"},     32'(bus.dut_b), 32'd0);
      check({tag, ".cin"},   32'(bus.dut_cin), 32'd0);
   endtask

   task automatic run(input string tag, input int fm, input int pulse,
                      input logic [7:0] e_err, input logic [7:0] e_first, input logic e_pass);
      vec_t v;
      fault_mode = fm;
      pulse_at   = pulse;
      build_queue();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      cyc = 1;
      #1;
      bus.start = 1'b0;
      check({tag, ".busy_start"}, 32'(bus.busy), 32'd1);
      for (int k = 0; k < int'(N); k++) begin
         tick();
         v = sb.pop_front();
         check($sformatf("%s.a[%0d]", tag, k),   32'(bus.dut_a),   32'(v.a));
         check($sformatf("%s.b[%0d]", tag, k),   32'(bus.dut_b),   32'(v.b));
         check($sformatf("%s.cin[%0d]", tag, k), 32'(bus.dut_cin), 32'(v.cin));
         if (fm == 0 && k < 4) begin
            check($sformatf("%s.corner_sum[%0d]", tag, k),  32'(bus.dut_sum),  32'(C_SUM[k]));
            check($sformatf("%s.corner_cout[%0d]", tag, k), 32'(bus.dut_cout), 32'(C_CO[k]));
         end
         tick();
         tick();
      end
      check({tag, ".done_early"}, 32'(bus.done), 32'd0);
      while (!bus.done && cyc < 700) tick();
      check({tag, ".latency"},  32'(cyc), 32'(RUN_CYCLES));
      check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
      check({tag, ".pass"},     32'(bus.pass), 32'(e_pass));
      check({tag, ".err"},      32'(bus.err_count), 32'(e_err));
      check({tag, ".first"},    32'(bus.first_err_idx), 32'(e_first));
      check({tag, ".nc_pass"},  32'(bus_nc.pass), 32'd1);
      check({tag, ".nc_err"},   32'(bus_nc.err_count), 32'd0);
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      cyc        = 0;
      pulse_at   = 0;
      fault_mode = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      @(negedge clk);
      bus.start = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      check("idle.busy", 32'(bus.busy), 32'd0);

      build_queue();
      run("golden", 0, 0, 8'd0, 8'hFF, 1'b1);
      run("stuck_sum0", 1, 0, 8'(stuck_errs), 8'd0, 1'b0);
      run("cout_inv", 2, 0, 8'(N), 8'd0, 1'b0);

      fault_mode = 1;
      pulse_at   = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      cyc = 1;
      #1;
      bus.start = 1'b0;
      while (cyc < 49) tick();
      check("abort.pre_first", 32'(bus.first_err_idx), 32'd0);
      check("abort.pre_busy",  32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_reset("abort");

      run("after_abort", 0, 0, 8'd0, 8'hFF, 1'b1);
      run("restart_ignored", 0, 100, 8'd0, 8'hFF, 1'b1);
      run("second_start", 0, 0, 8'd0, 8'hFF, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
